// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage F/D/E/M/W pipeline.
// Define HAZARD_PERF_CNT_EN to add the saturating StallCnt/FlushCnt counters.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       WA3D,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             PCWrPendingD,
    input  logic             BranchTakenE,
    input  logic             CondExE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
`endif
);

    logic       e_valid;
    logic       e_regwrite;
    logic       e_memtoreg;
    logic       e_pcwr;
    logic [3:0] e_wa3;
    logic [3:0] e_ra1;
    logic [3:0] e_ra2;

    // Later stages keep only the fields that forwarding and PC-write tracking read.
    logic       m_valid;
    logic       m_regwrite;
    logic       m_pcwr;
    logic [3:0] m_wa3;

    logic       w_valid;
    logic       w_regwrite;
    logic [3:0] w_wa3;

    logic       ldrstall;
    logic       pcwr_pending_f;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_valid    <= 1'b0;
            e_regwrite <= 1'b0;
            e_memtoreg <= 1'b0;
            e_pcwr     <= 1'b0;
            e_wa3      <= 4'd0;
            e_ra1      <= 4'd0;
            e_ra2      <= 4'd0;
            m_valid    <= 1'b0;
            m_regwrite <= 1'b0;
            m_pcwr     <= 1'b0;
            m_wa3      <= 4'd0;
            w_valid    <= 1'b0;
            w_regwrite <= 1'b0;
            w_wa3      <= 4'd0;
        end else begin
            if (FlushE) begin
                e_valid    <= 1'b0;
                e_regwrite <= 1'b0;
                e_memtoreg <= 1'b0;
                e_pcwr     <= 1'b0;
                e_wa3      <= 4'd0;
                e_ra1      <= 4'd0;
                e_ra2      <= 4'd0;
            end else begin
                e_valid    <= 1'b1;
                e_regwrite <= RegWriteD;
                e_memtoreg <= MemtoRegD;
                e_pcwr     <= PCWrPendingD;
                e_wa3      <= WA3D;
                e_ra1      <= RA1D;
                e_ra2      <= RA2D;
            end
            // A failed condition cancels the register and PC writes of the E instruction.
            m_valid    <= e_valid;
            m_regwrite <= e_regwrite & CondExE;
            m_pcwr     <= e_pcwr & CondExE;
            m_wa3      <= e_wa3;
            w_valid    <= m_valid;
            w_regwrite <= m_regwrite;
            w_wa3      <= m_wa3;
        end
    end

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (e_ra1 != 4'd15) begin
            if (m_valid && m_regwrite && (m_wa3 == e_ra1))
                ForwardAE = 2'b10;
            else if (w_valid && w_regwrite && (w_wa3 == e_ra1))
                ForwardAE = 2'b01;
        end
        if (e_ra2 != 4'd15) begin
            if (m_valid && m_regwrite && (m_wa3 == e_ra2))
                ForwardBE = 2'b10;
            else if (w_valid && w_regwrite && (w_wa3 == e_ra2))
                ForwardBE = 2'b01;
        end
    end

    // A taken branch overrides a load-use stall: the dependent instruction is discarded anyway.
    assign ldrstall       = e_valid & e_memtoreg & ((e_wa3 == RA1D) | (e_wa3 == RA2D));
    assign pcwr_pending_f = PCWrPendingD | (e_valid & e_pcwr) | (m_valid & m_pcwr);
    assign StallD         = ldrstall & ~BranchTakenE;
    assign StallF         = (ldrstall | pcwr_pending_f) & ~BranchTakenE;
    assign FlushD         = pcwr_pending_f | BranchTakenE;
    assign FlushE         = ldrstall | BranchTakenE;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_one;
    assign cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if ((StallD || StallF) && !(&StallCnt))
                StallCnt <= StallCnt + cnt_one;
            if (FlushE && !(&FlushCnt))
                FlushCnt <= FlushCnt + cnt_one;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed instruction sequences with hand-derived expectations.
// Counter checks are compiled in when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

    localparam int TB_CNT_W = 4;

    // ctl = {RegWriteD, MemtoRegD, PCWrPendingD, BranchTakenE, CondExE}
    localparam logic [4:0] C_NOP    = 5'b00001;
    localparam logic [4:0] C_ALU    = 5'b10001;
    localparam logic [4:0] C_ALU_NC = 5'b10000;
    localparam logic [4:0] C_LDR    = 5'b11001;
    localparam logic [4:0] C_PCW    = 5'b00101;
    localparam logic [4:0] C_PCWR   = 5'b10101;
    localparam logic [4:0] C_BT     = 5'b00011;
    localparam logic [4:0] C_ALU_BT = 5'b10011;

    // exp = {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE}
    localparam logic [7:0] E_NONE = 8'b00_00_0000;
    localparam logic [7:0] E_FA10 = 8'b10_00_0000;
    localparam logic [7:0] E_FAB2 = 8'b10_10_0000;
    localparam logic [7:0] E_FB01 = 8'b00_01_0000;
    localparam logic [7:0] E_FAB1 = 8'b01_01_0000;
    localparam logic [7:0] E_LDST = 8'b00_00_1101;
    localparam logic [7:0] E_PCW  = 8'b00_00_1010;
    localparam logic [7:0] E_BT   = 8'b00_00_0011;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] RA1D, RA2D, WA3D;
    logic       RegWriteD, MemtoRegD, PCWrPendingD, BranchTakenE, CondExE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, FlushD, FlushE;
`ifdef HAZARD_PERF_CNT_EN
    logic [TB_CNT_W-1:0] StallCnt, FlushCnt;
`endif

    logic [7:0] obs_vec;
    assign obs_vec = {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE};

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .WA3D         (WA3D),
        .RegWriteD    (RegWriteD),
        .MemtoRegD    (MemtoRegD),
        .PCWrPendingD (PCWrPendingD),
        .BranchTakenE (BranchTakenE),
        .CondExE      (CondExE),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .FlushE       (FlushE)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .StallCnt     (StallCnt),
        .FlushCnt     (FlushCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic drive_inputs(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                                input logic [4:0] ctl);
        RA1D = ra1;
        RA2D = ra2;
        WA3D = wa3;
        {RegWriteD, MemtoRegD, PCWrPendingD, BranchTakenE, CondExE} = ctl;
    endtask

    // Drive one D-stage instruction, queue the expected outputs, then compare mid-cycle.
    task automatic applyStimulus(input string tag, input logic [3:0] ra1, input logic [3:0] ra2,
                                 input logic [3:0] wa3, input logic [4:0] ctl, input logic [7:0] exp);
        sb_entry_t ent;
        @(negedge clk);
        drive_inputs(ra1, ra2, wa3, ctl);
        ent.tag = tag;
        ent.exp = exp;
        sb_q.push_back(ent);
        #2;
        ent = sb_q.pop_front();
        checkOutput(ent.tag, {24'd0, obs_vec}, {24'd0, ent.exp});
    endtask

    task automatic check_counters(input string tag, input int exp_stall, input int exp_flush);
`ifdef HAZARD_PERF_CNT_EN
        checkOutput({tag, "_stallcnt"}, {28'd0, StallCnt}, exp_stall);
        checkOutput({tag, "_flushcnt"}, {28'd0, FlushCnt}, exp_flush);
`else
        if (exp_stall < 0 || exp_flush < 0)
            $display("[TB] counters not built for %s", tag);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_inputs(4'd0, 4'd0, 4'd0, 5'b00000);
        reset = 1'b0;
        #2;
        checkOutput("reset_outputs", {24'd0, obs_vec}, 32'd0);
        check_counters("reset", 0, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic load_use_pair(input string tag);
        applyStimulus({tag, "_ldr_d"},   4'd0, 4'd0, 4'd1, C_LDR, E_NONE);
        applyStimulus({tag, "_stall"},   4'd1, 4'd1, 4'd2, C_ALU, E_LDST);
        applyStimulus({tag, "_bubble"},  4'd1, 4'd1, 4'd2, C_ALU, E_NONE);
        applyStimulus({tag, "_fwd_w"},   4'd0, 4'd0, 4'd0, C_NOP, E_FAB1);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        drive_inputs(4'd0, 4'd0, 4'd0, 5'b00000);
        do_reset();

        applyStimulus("add_d",       4'd2, 4'd3, 4'd1, C_ALU, E_NONE);
        applyStimulus("sub_d",       4'd1, 4'd5, 4'd4, C_ALU, E_NONE);
        applyStimulus("sub_e_fwdm",  4'd0, 4'd0, 4'd0, C_NOP, E_FA10);
        applyStimulus("sub_m",       4'd0, 4'd0, 4'd0, C_NOP, E_NONE);

        do_reset();
        applyStimulus("prio_add1",   4'd2, 4'd3, 4'd1, C_ALU, E_NONE);
        applyStimulus("prio_add2",   4'd6, 4'd7, 4'd1, C_ALU, E_NONE);
        applyStimulus("prio_sub",    4'd1, 4'd1, 4'd4, C_ALU, E_NONE);
        applyStimulus("prio_m_wins", 4'd0, 4'd0, 4'd0, C_NOP, E_FAB2);

        do_reset();
        applyStimulus("orr_add",     4'd2, 4'd3, 4'd1, C_ALU, E_NONE);
        applyStimulus("orr_nop",     4'd0, 4'd0, 4'd0, C_NOP, E_NONE);
        applyStimulus("orr_d",       4'd7, 4'd1, 4'd6, C_ALU, E_NONE);
        applyStimulus("orr_e_fwdw",  4'd0, 4'd0, 4'd0, C_NOP, E_FB01);

        do_reset();
        load_use_pair("lu");

        do_reset();
        applyStimulus("cf_add",      4'd2, 4'd3, 4'd1, C_ALU,    E_NONE);
        applyStimulus("cf_sub",      4'd1, 4'd5, 4'd4, C_ALU_NC, E_NONE);
        applyStimulus("cf_no_fwd",   4'd0, 4'd0, 4'd0, C_NOP,    E_NONE);

        do_reset();
        applyStimulus("r15_wr",      4'd2,  4'd3,  4'd15, C_ALU, E_NONE);
        applyStimulus("r15_rd",      4'd15, 4'd15, 4'd4,  C_ALU, E_NONE);
        applyStimulus("r15_no_fwd",  4'd0,  4'd0,  4'd0,  C_NOP, E_NONE);

        do_reset();
        applyStimulus("br_d",        4'd0, 4'd0, 4'd0, C_PCW, E_PCW);
        applyStimulus("br_taken",    4'd0, 4'd0, 4'd0, C_BT,  E_BT);
        applyStimulus("br_m",        4'd0, 4'd0, 4'd0, C_NOP, E_PCW);
        applyStimulus("br_w",        4'd0, 4'd0, 4'd0, C_NOP, E_NONE);
        check_counters("br", 2, 1);

        do_reset();
        applyStimulus("pcw_d",       4'd0, 4'd0, 4'd15, C_PCWR, E_PCW);
        applyStimulus("pcw_e",       4'd0, 4'd0, 4'd0,  C_NOP,  E_PCW);
        applyStimulus("pcw_m",       4'd0, 4'd0, 4'd0,  C_NOP,  E_PCW);
        applyStimulus("pcw_w",       4'd0, 4'd0, 4'd0,  C_NOP,  E_NONE);

        do_reset();
        applyStimulus("sim_ldr",     4'd0, 4'd0, 4'd1, C_LDR,    E_NONE);
        applyStimulus("sim_br_wins", 4'd1, 4'd1, 4'd2, C_ALU_BT, E_BT);

        // Pull reset mid-cycle while the load-use stall is showing.
        do_reset();
        applyStimulus("ar_ldr",      4'd0, 4'd0, 4'd1, C_LDR, E_NONE);
        applyStimulus("ar_stall",    4'd1, 4'd1, 4'd2, C_ALU, E_LDST);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("async_reset", {24'd0, obs_vec}, 32'd0);
        check_counters("async_reset", 0, 0);
        @(negedge clk);
        drive_inputs(4'd0, 4'd0, 4'd0, 5'b00000);
        reset = 1'b1;
        load_use_pair("relu");

        do_reset();
        for (int i = 0; i < 20; i++)
            applyStimulus($sformatf("sat_%0d", i), 4'd0, 4'd0, 4'd0, C_PCW, E_PCW);
        check_counters("sat", 15, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
